// File: rtl/bus_controller_pkg.sv
// Shared encodings for the bus control sequencer: timesteps, opcodes,
// ALU function codes and the instruction word field layout.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            default: code = ALU_PASS;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bus_controller_decoder.sv
// Register index to one-hot decoder; all zeros unless enabled so that an
// idle cycle can never leave a stray load or bus select asserted.
module reg_index_decoder #(
    parameter int NUM_REGS = 8
) (
    input  logic [$clog2(NUM_REGS)-1:0] index,
    input  logic                        enable,
    output logic [NUM_REGS-1:0]         onehot
);

    // One-hot expansion of the index, gated by enable
    always_comb begin
        onehot = '0;
        if (enable) begin
            onehot[index] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// Control sequencer for the 16-bit datapath bus: decodes III XXX YYY and
// drives mux selects / load enables combinationally over timesteps T0-T3.
module bus_controller
    import bus_ctrl_pkg::*;
#(
    parameter int IR_WIDTH = 9,
    parameter int NUM_REGS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [IR_WIDTH-1:0] ir,
    output logic                done,
    output logic                irin,
    output logic [NUM_REGS-1:0] rin,
    output logic                ain,
    output logic                gin,
    output logic [1:0]          alu_op,
    output logic                imediate_select,
    output logic                r0_select,
    output logic                r1_select,
    output logic                r2_select,
    output logic                r3_select,
    output logic                r4_select,
    output logic                r5_select,
    output logic                r6_select,
    output logic                r7_select,
    output logic                r_select
);

    localparam int IDX_W = $clog2(NUM_REGS);

    tstep_t              state;
    tstep_t              state_nxt;
    logic [IR_WIDTH-1:0] ir_reg;
    logic [2:0]          op;
    logic [IDX_W-1:0]    rx;
    logic [IDX_W-1:0]    ry;
    logic                rin_en;
    logic                sel_en;
    logic [IDX_W-1:0]    sel_idx;
    logic [NUM_REGS-1:0] sel_onehot;

    assign op = ir_reg[OP_MSB:OP_LSB];
    assign rx = ir_reg[RX_MSB:RX_LSB];
    assign ry = ir_reg[RY_MSB:RY_LSB];

    // Timestep and instruction register
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= T0;
            ir_reg <= '0;
        end else begin
            state <= state_nxt;
            if (irin) begin
                ir_reg <= ir;
            end
        end
    end

    // Next timestep; combinations an opcode never visits fall back to T0
    always_comb begin
        state_nxt = T0;
        case (state)
            T0:      state_nxt = run ? T1 : T0;
            T1:      state_nxt = is_alu_op(op) ? T2 : T0;
            T2:      state_nxt = is_alu_op(op) ? T3 : T0;
            T3:      state_nxt = T0;
            default: state_nxt = T0;
        endcase
    end

    // Control decode; reset forces every output low in the same cycle
    always_comb begin
        irin            = 1'b0;
        done            = 1'b0;
        ain             = 1'b0;
        gin             = 1'b0;
        alu_op          = ALU_ADD;
        imediate_select = 1'b0;
        r_select        = 1'b0;
        rin_en          = 1'b0;
        sel_en          = 1'b0;
        sel_idx         = '0;
        if (!reset) begin
            case (state)
                T0: irin = run;
                T1: begin
                    case (op)
                        OP_MV: begin
                            sel_en  = 1'b1;
                            sel_idx = ry;
                            rin_en  = 1'b1;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            imediate_select = 1'b1;
                            rin_en          = 1'b1;
                            done            = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            sel_en  = 1'b1;
                            sel_idx = rx;
                            ain     = 1'b1;
                        end
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    if (is_alu_op(op)) begin
                        sel_en  = 1'b1;
                        sel_idx = ry;
                        gin     = 1'b1;
                        alu_op  = alu_code(op);
                    end else begin
                        sel_en = 1'b0;
                    end
                end
                T3: begin
                    if (is_alu_op(op)) begin
                        r_select = 1'b1;
                        rin_en   = 1'b1;
                        done     = 1'b1;
                    end else begin
                        rin_en = 1'b0;
                    end
                end
                default: irin = 1'b0;
            endcase
        end else begin
            irin = 1'b0;
        end
    end

    reg_index_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .index  (rx),
        .enable (rin_en),
        .onehot (rin)
    );

    reg_index_decoder #(.NUM_REGS(NUM_REGS)) u_sel_dec (
        .index  (sel_idx),
        .enable (sel_en),
        .onehot (sel_onehot)
    );

    assign r0_select = sel_onehot[0];
    assign r1_select = sel_onehot[1];
    assign r2_select = sel_onehot[2];
    assign r3_select = sel_onehot[3];
    assign r4_select = sel_onehot[4];
    assign r5_select = sel_onehot[5];
    assign r6_select = sel_onehot[6];
    assign r7_select = sel_onehot[7];

endmodule

// File: tb/tb_bus_controller.sv
// Scoreboard bench for bus_controller: each cycle's expected output vector is
// queued as stimulus is driven and compared once the cycle's outputs settle.
module tb_bus_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run   = 1'b0;
    logic [8:0] ir    = 9'd0;
    logic       done, irin, ain, gin, imediate_select, r_select;
    logic [7:0] rin;
    logic [1:0] alu_op;
    logic r0_select, r1_select, r2_select, r3_select;
    logic r4_select, r5_select, r6_select, r7_select;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    localparam logic [23:0] IDLE = 24'h000000;

    bus_controller dut (
        .clock(clock), .reset(reset), .run(run), .ir(ir),
        .done(done), .irin(irin), .rin(rin), .ain(ain), .gin(gin),
        .alu_op(alu_op), .imediate_select(imediate_select),
        .r0_select(r0_select), .r1_select(r1_select), .r2_select(r2_select),
        .r3_select(r3_select), .r4_select(r4_select), .r5_select(r5_select),
        .r6_select(r6_select), .r7_select(r7_select), .r_select(r_select)
    );

    always #5 clock = ~clock;

    // Vector layout: done, irin, rin[7:0], ain, gin, alu_op, imm, r7..r0 select, r_select
    function automatic logic [23:0] ev(input logic dn, input logic ii, input logic [7:0] ri,
                                       input logic a, input logic g, input logic [1:0] op,
                                       input logic im, input logic [7:0] sl, input logic rs);
        return {dn, ii, ri, a, g, op, im, sl, rs};
    endfunction

    task automatic drive(input logic rs, input logic rn, input logic [8:0] iw,
                         input logic [23:0] expv);
        @(posedge clock);
        #1;
        reset = rs;
        run   = rn;
        ir    = iw;
        exp_q.push_back(expv);
        @(negedge clock);
        obs_q.push_back({done, irin, rin, ain, gin, alu_op, imediate_select,
                         r7_select, r6_select, r5_select, r4_select,
                         r3_select, r2_select, r1_select, r0_select, r_select});
    endtask

    task automatic test_reset();
        logic [23:0] e, o;
        int k = 0;
        drive(1'b1, 1'b1, 9'b010_000_001, IDLE);
        drive(1'b1, 1'b1, 9'b010_000_001, IDLE);
        drive(1'b0, 1'b1, 9'b010_000_001, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(0,0,8'h00,1,0,2'b00,0,8'h01,0));
        drive(1'b1, 1'b0, 9'd0,           IDLE);
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        drive(1'b0, 1'b1, 9'b000_001_010, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h02,0,0,2'b00,0,8'h04,0));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_mvi_mv();
        logic [23:0] e, o;
        int k = 0;
        drive(1'b0, 1'b1, 9'b001_010_000, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h04,0,0,2'b00,1,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        drive(1'b0, 1'b1, 9'b000_101_011, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h20,0,0,2'b00,0,8'h08,0));
        drive(1'b0, 1'b1, 9'b000_011_011, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h08,0,0,2'b00,0,8'h08,0));
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mvi_mv[%0d]: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_alu();
        logic [23:0] e, o;
        int k = 0;
        // sub R1,R6 with run and ir wiggling outside T0
        drive(1'b0, 1'b1, 9'b011_001_110, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b1, 9'h1FF,         ev(0,0,8'h00,1,0,2'b00,0,8'h02,0));
        drive(1'b0, 1'b0, 9'h000,         ev(0,0,8'h00,0,1,2'b01,0,8'h40,0));
        drive(1'b0, 1'b1, 9'h0AA,         ev(1,0,8'h02,0,0,2'b00,0,8'h00,1));
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        // and R3,R3
        drive(1'b0, 1'b1, 9'b100_011_011, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(0,0,8'h00,1,0,2'b00,0,8'h08,0));
        drive(1'b0, 1'b0, 9'd0,           ev(0,0,8'h00,0,1,2'b10,0,8'h08,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h08,0,0,2'b00,0,8'h00,1));
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL alu[%0d]: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e, o;
        int k = 0;
        drive(1'b0, 1'b1, 9'b010_000_001, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b1, 9'b000_100_000, ev(0,0,8'h00,1,0,2'b00,0,8'h01,0));
        drive(1'b0, 1'b1, 9'b000_100_000, ev(0,0,8'h00,0,1,2'b00,0,8'h02,0));
        drive(1'b0, 1'b1, 9'b000_100_000, ev(1,0,8'h01,0,0,2'b00,0,8'h00,1));
        drive(1'b0, 1'b1, 9'b000_100_000, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'b000_100_000, ev(1,0,8'h10,0,0,2'b00,0,8'h01,0));
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h expected %h", k, o, e);
            end
            n_tests++;
            if ($countones(o[9:0]) > 1 || $countones(o[21:14]) > 1) begin
                n_fail++;
                $display("FAIL b2b_onehot[%0d]: got %h expected at most one select and one rin", k, o);
            end
            k++;
        end
    endtask

    task automatic test_reserved_idle();
        logic [23:0] e, o;
        int k = 0;
        drive(1'b0, 1'b1, 9'b111_000_000, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           IDLE);
        drive(1'b0, 1'b1, 9'b101_111_111, ev(0,1,8'h00,0,0,2'b00,0,8'h00,0));
        drive(1'b0, 1'b0, 9'd0,           ev(1,0,8'h00,0,0,2'b00,0,8'h00,0));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 9'($urandom_range(0, 511)), IDLE);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reserved_idle[%0d]: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_mvi_mv();
        test_alu();
        test_back_to_back();
        test_reserved_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Control sequencer for the 16-bit datapath bus; drives the select inputs of the bus multiplexer and the load enables of registers R0-R7, A, G and IR.
- Decodes a 9-bit instruction (III XXX YYY) and sequences it over timesteps T0-T3.
- Issues at most one bus select per cycle, because the multiplexer is priority-encoded and would otherwise mask conflicts.

Parameters:
- IR_WIDTH, 9, instruction width: opcode [8:6], Rx [5:3], Ry [2:0].
- NUM_REGS, 8, general registers; the one-hot vectors are NUM_REGS wide.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- run  input  1  start request, sampled only in T0.
- ir  input  9  instruction word, valid while irin is asserted.
- done  output  1  one-cycle pulse on the final cycle of each instruction.
- irin  output  1  load enable for the IR register.
- rin  output  8  one-hot load enable for R0-R7.
- ain  output  1  load enable for ALU operand register A.
- gin  output  1  load enable for ALU result register G.
- alu_op  output  2  ALU function: 00 add, 01 sub, 10 and, 11 pass.
- imediate_select  output  1  bus select for the immediate word.
- r0_select..r7_select  output  1 each  bus select for R0-R7.
- r_select  output  1  bus select for G.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
  - While reset is high: state goes to T0 on the edge, and every output is 0 in that cycle, including irin.
  - Reset mid-instruction aborts it: no done, no further enables.
- Internal state:
  - 2-bit timestep register (T0..T3).
  - Internal 9-bit instruction register, loaded from ir when irin=1.
- Output style: outputs are combinational decodes of (timestep, internal IR). They are not registered, so an enable is asserted in the same cycle the bus carries its data.
- Idle outputs: alu_op = 00 whenever gin = 0. All unlisted outputs are 0.
- Invariant: at most one of {imediate_select, r0..r7_select, r_select} is high in any cycle. At most one rin bit is high.
- T0:
  - irin = run.
  - run=1: capture ir, go to T1.
  - run=0: stay in T0.
- Opcode 000, mv Rx,Ry:
  - T1: rY_select=1, rin[X]=1, done=1, go to T0.
- Opcode 001, mvi Rx,#D:
  - T1: imediate_select=1, rin[X]=1, done=1, go to T0.
- Opcodes 010 add / 011 sub / 100 and:
  - T1: rX_select=1, ain=1.
  - T2: rY_select=1, gin=1, alu_op = 00 / 01 / 10 respectively.
  - T3: r_select=1, rin[X]=1, done=1, go to T0.
- Opcodes 101-111 (reserved): T1 asserts done only, with no selects or enables. Go to T0.
- Latency, measured from the T0 cycle with run=1:
  - mv and mvi: done on cycle +1.
  - ALU ops: done on cycle +3.
  - With run held high, the next T0 immediately follows the done cycle.
- Boundary cases:
  - X=Y is legal. mv R3,R3 asserts r3_select and rin[3] together. add R3,R3 doubles R3.
  - run toggling outside T0 is ignored.
  - ir changing outside irin cycles has no effect.
- Unreachable states decode to all-zero outputs and return to T0.

Decomposition:
- Shared package bus_ctrl_pkg:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND.
  - timestep encoding T0..T3.
  - ALU_ADD/SUB/AND/PASS codes.
  - field positions of ir.
- Sub-module reg_index_decoder: 3-bit index plus enable in, 8-bit one-hot out, all zeros when enable=0.
  - Instantiated twice: once for rin, once for the R0-R7 select group.

Test Plan:
- Reset while in T2 of an add -> next cycle state T0; all outputs 0; no done.
- run=1, ir=001_010_000 (mvi R2) -> T1: imediate_select=1, rin=8'b00000100, done=1; all other selects 0.
- run=1, ir=000_101_011 (mv R5,R3) -> T1: r3_select=1, rin=8'b00100000, done=1.
- run=1, ir=011_001_110 (sub R1,R6):
  - T1: r1_select=1, ain=1.
  - T2: r6_select=1, gin=1, alu_op=01.
  - T3: r_select=1, rin=8'b00000010, done=1.
- run held 1 with back-to-back add R0,R1 then mv R4,R0 -> done on cycles 3 and 5; irin high on cycles 0 and 4; at most one select bit high in every cycle.
- ir=111_000_000 -> T1: done=1, rin=0, all selects 0. Also: run=0 for 10 cycles -> stays in T0 with all outputs 0.
